// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and channel state encoding shared by the PWM
// generator and the pwm_duty_capture receive path.
package pwm_pkg;

    localparam int DUTY_W       = 7;
    localparam int PWM_UNIT     = 62;
    localparam int PWM_MAX_DUTY = 100;
    localparam int PWM_TIMEOUT  = 8191;
    localparam int IDLE_W       = 13;
    localparam int PERIOD_W     = 14;
    localparam int PERIOD_MIN   = 6000;
    localparam int PERIOD_MAX   = 6400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/pwm_capture_ch.sv
// pwm_capture_ch: one PWM receive channel. Synchronizes the raw line,
// measures high time in UNIT-cycle steps and publishes the duty of the
// previous rise-to-rise period; a static line publishes 0 or MAX_DUTY.
// Ports: clk; rst (async, active high); pwm_in (raw line);
//        duty (recovered duty); valid (1-cycle update strobe);
//        period_err (sticky period fault flag).
// Build option: PWM_PERIOD_CHECK_EN adds the rise-to-rise period check;
// without it period_err is tied low.
module pwm_capture_ch
    import pwm_pkg::*;
#(
    parameter int UNIT        = PWM_UNIT,
    parameter int MAX_DUTY    = PWM_MAX_DUTY,
    parameter int TIMEOUT     = PWM_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              period_err
);

    localparam int PRE_W = (UNIT > 1) ? $clog2(UNIT) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(UNIT - 1);
    localparam logic [DUTY_W-1:0] DUTY_SAT = DUTY_W'(MAX_DUTY);
    localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(TIMEOUT);

    ch_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_dly_q, lvl_dly_d;
    logic [PRE_W-1:0]       pre_q, pre_d, pre_nx;
    logic [DUTY_W-1:0]      units_q, units_d, units_nx;
    logic [DUTY_W-1:0]      held_q, held_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic                   valid_q, valid_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   lvl, rise, fall, timeout;

    assign lvl       = sync_q[SYNC_STAGES-1];
    assign rise      = lvl & ~lvl_dly_q;
    assign fall      = ~lvl & lvl_dly_q;
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
    assign lvl_dly_d = lvl;
    // Fires once: idle then sits at IDLE_SAT until the next edge.
    assign timeout   = ~(rise | fall) &&
                       (idle_q == IDLE_SAT - IDLE_W'(1));

    always_comb begin
        pre_nx   = pre_q + PRE_W'(1);
        units_nx = units_q;
        if (pre_q == PRE_LAST) begin
            pre_nx = '0;
            if (units_q != DUTY_SAT) begin
                units_nx = units_q + DUTY_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        units_d = units_q;
        held_d  = held_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        idle_d  = idle_q;

        if (rise || fall) begin
            idle_d = '0;
        end else if (idle_q != IDLE_SAT) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    pre_d   = '0;
                    units_d = '0;
                    state_d = HIGH;
                end else if (fall) begin
                    units_d = '0;
                    state_d = LOW;
                end
            end
            HIGH: begin
                pre_d   = pre_nx;
                units_d = units_nx;
                // Include the falling cycle so UNIT*d high cycles give d.
                if (fall) begin
                    held_d  = units_nx;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    duty_d  = (held_q > DUTY_SAT) ? DUTY_SAT : held_q;
                    valid_d = 1'b1;
                    pre_d   = '0;
                    units_d = '0;
                    state_d = HIGH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            duty_d  = lvl ? DUTY_SAT : '0;
            valid_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            lvl_dly_q <= 1'b0;
            pre_q     <= '0;
            units_q   <= '0;
            held_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            lvl_dly_q <= lvl_dly_d;
            pre_q     <= pre_d;
            units_q   <= units_d;
            held_q    <= held_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
        end
    end

    assign duty  = duty_q;
    assign valid = valid_q;

`ifdef PWM_PERIOD_CHECK_EN
    localparam int PLEN_W = PERIOD_W + 1;

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PLEN_W-1:0]   period_len;
    logic                err_q, err_d;
    logic                publish;

    // period_q holds cycles-1 since the last rise when the next rise lands.
    assign period_len = {1'b0, period_q} + PLEN_W'(1);
    assign publish    = (state_q == LOW) && rise;

    always_comb begin
        period_d = period_q;
        err_d    = err_q;
        if (rise) begin
            period_d = '0;
        end else if (period_q != '1) begin
            period_d = period_q + PERIOD_W'(1);
        end
        if (publish &&
            (period_len < PLEN_W'(PERIOD_MIN) ||
             period_len > PLEN_W'(PERIOD_MAX))) begin
            err_d = 1'b1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            err_q    <= err_d;
        end
    end

    assign period_err = err_q;
`else
    assign period_err = 1'b0;
`endif

endmodule

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: CH-channel PWM duty decoder, receive-side mirror of
// the motor PWM generator. Channel i duty sits in duty[7i+6:7i].
// Ports: clk (50 MHz); rst (async, active high); pwm_in[CH] (raw lines);
//        duty[7*CH] (packed duty); valid[CH] (per-channel update strobe);
//        period_err[CH] (sticky period fault flags).
// Build option: PWM_PERIOD_CHECK_EN enables the per-channel period check.
module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int CH          = 4,
    parameter int UNIT        = PWM_UNIT,
    parameter int MAX_DUTY    = PWM_MAX_DUTY,
    parameter int TIMEOUT     = PWM_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        pwm_in,
    output logic [DUTY_W*CH-1:0] duty,
    output logic [CH-1:0]        valid,
    output logic [CH-1:0]        period_err
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_capture_ch #(
            .UNIT        (UNIT),
            .MAX_DUTY    (MAX_DUTY),
            .TIMEOUT     (TIMEOUT),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pwm_in     (pwm_in[i]),
            .duty       (duty[DUTY_W*i +: DUTY_W]),
            .valid      (valid[i]),
            .period_err (period_err[i])
        );
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture: scoreboard bench for pwm_duty_capture; a pin-level
// reference model queues expected results, a monitor checks strobes.
module tb_pwm_duty_capture;

    localparam int CH   = 4;
    localparam int UNIT = 62;
    localparam int MAXD = 100;
    localparam int TOUT = 8191;
    localparam int SYNC = 2;
    localparam int PMIN = 6000;
    localparam int PMAX = 6400;

`ifdef PWM_PERIOD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] duty;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   pwm_in;
    logic [7*CH-1:0] duty;
    logic [CH-1:0]   valid;
    logic [CH-1:0]   period_err;

    int n_cmp = 0;
    int n_bad = 0;
    int mcyc  = 0;

    exp_t exp_q[CH][$];
    bit   m_prev[CH];
    bit   m_ref[CH];
    bit   m_fell[CH];
    bit   m_to[CH];
    bit   m_err[CH];
    int   m_rise[CH];
    int   m_hi[CH];
    int   m_last[CH];

    bit t2_arm  = 1'b0;
    int t2      = 0;
    int rel_cyc = 0;
    int bnd_hi[4] = '{61, 62, 63, 124};

    pwm_duty_capture #(
        .CH          (CH),
        .UNIT        (UNIT),
        .MAX_DUTY    (MAXD),
        .TIMEOUT     (TOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .valid      (valid),
        .period_err (period_err)
    );

    always #10 clk = ~clk;

    function automatic logic [6:0] duty_of(input int hi);
        int d;
        d = hi / UNIT;
        return (d > MAXD) ? 7'(MAXD) : 7'(d);
    endfunction

    // Reference model on the pin timeline: a result is owed at every rise
    // that closes a complete high/low period, or after TOUT quiet cycles.
    always @(posedge clk) begin
        bit lv;
        int p;
        mcyc++;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_prev[c] = 1'b0;
                m_ref[c]  = 1'b0;
                m_fell[c] = 1'b0;
                m_to[c]   = 1'b0;
                m_err[c]  = 1'b0;
                m_last[c] = mcyc;
                exp_q[c].delete();
            end else begin
                lv = pwm_in[c];
                if (lv && !m_prev[c]) begin
                    if (m_ref[c] && m_fell[c]) begin
                        p = mcyc - m_rise[c];
                        if (CHK && (p < PMIN || p > PMAX)) m_err[c] = 1'b1;
                        exp_q[c].push_back('{duty_of(m_hi[c]), m_err[c]});
                    end
                    m_ref[c]  = 1'b1;
                    m_fell[c] = 1'b0;
                    m_rise[c] = mcyc;
                    m_last[c] = mcyc;
                    m_to[c]   = 1'b0;
                end else if (!lv && m_prev[c]) begin
                    m_hi[c]   = mcyc - m_rise[c];
                    m_fell[c] = 1'b1;
                    m_last[c] = mcyc;
                    m_to[c]   = 1'b0;
                end else if (!m_to[c] && mcyc - m_last[c] == TOUT) begin
                    if (CHK) m_err[c] = 1'b1;
                    exp_q[c].push_back('{lv ? 7'(MAXD) : 7'd0, m_err[c]});
                    m_to[c]   = 1'b1;
                    m_ref[c]  = 1'b0;
                    m_fell[c] = 1'b0;
                end
                m_prev[c] = lv;
            end
        end
    end

    // Monitor: every strobe must match the oldest owed result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                if (valid[c]) begin
                    if (c == 2 && t2_arm) begin
                        t2     = mcyc;
                        t2_arm = 1'b0;
                    end
                    n_cmp++;
                    if (exp_q[c].size() == 0) begin
                        n_bad++;
                        $display("FAIL strobe ch%0d: got duty %0d, expected no strobe",
                                 c, duty[7*c +: 7]);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (duty[7*c +: 7] !== e.duty ||
                            period_err[c] !== e.err) begin
                            n_bad++;
                            $display("FAIL duty ch%0d: got %0d err %0b, expected %0d err %0b",
                                     c, duty[7*c +: 7], period_err[c], e.duty, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int c, input int hi, input int lo);
        pwm_in[c] = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in[c] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int left;
        left = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            left = exp_q[0].size() + exp_q[1].size() +
                   exp_q[2].size() + exp_q[3].size();
            if (left == 0) break;
        end
        chk(tag, left, 0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int p;
        int h;
        bit in_win;

        rst    = 1'b1;
        pwm_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_duty", duty, 0);
        chk("reset_valid", valid, 0);
        chk("reset_err", period_err, 0);
        rst = 1'b0;

        // Duty 50, min/max pulses, boundary rounding, 5000-cycle period.
        fork
            begin
                for (int i = 0; i < 4; i++) pulse(0, 3101, 3100);
                pwm_in[0] = 1'b1;
            end
            begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                pulse(1, 1, 6200);
                pulse(1, 1, 6200);
                pulse(1, 6201, 1);
                pulse(1, 6201, 1);
                pwm_in[1] = 1'b1;
            end
            begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                for (int i = 0; i < 4; i++)
                    pulse(2, bnd_hi[i], 6201 - bnd_hi[i]);
                pwm_in[2] = 1'b1;
            end
            begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                for (int i = 0; i < 5; i++) pulse(3, 2500, 2500);
                pwm_in[3] = 1'b1;
            end
        join
        drain("drain_a");

        // Static lines plus reset in the middle of a duty-30 high phase.
        @(negedge clk);
        rst    = 1'b1;
        pwm_in = 4'b1000;
        do_reset();
        pulse(0, 1861, 4340);
        pwm_in[0] = 1'b1;
        k = $urandom_range(100, 1700);
        repeat (k) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_duty", duty, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", period_err, 0);
        repeat (1861 - k) @(negedge clk);
        pwm_in[0] = 1'b0;
        repeat (1000) @(negedge clk);
        rst     = 1'b0;
        rel_cyc = mcyc;
        t2_arm  = 1'b1;
        fork
            begin
                repeat (3340) @(negedge clk);
                pulse(0, 1861, 4340);
                pulse(0, 1861, 4340);
                pwm_in[0] = 1'b1;
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    p = $urandom_range(5000, 7000);
                    h = $urandom_range(1, p - 1);
                    pulse(1, h, p - h);
                end
                pwm_in[1] = 1'b1;
            end
        join
        drain("drain_c");
        in_win = (t2 - rel_cyc >= TOUT) && (t2 - rel_cyc <= TOUT + SYNC + 2);
        chk("static_latency", 32'(in_win), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
- 4-channel PWM decoder, the receive-side counterpart of the motor-drive PWM generator.
- Measures the high time of each incoming PWM line and recovers a 7-bit duty value (0..100) per channel.
- Output uses the same 28-bit packed layout the generator consumes.
- Used for loopback self-test of the motor PWM path and for reading PWM-style sensor and servo feedback on the 50 MHz clock.

Parameters:
- CH, 4: number of channels; packed duty width is 7*CH.
- UNIT, 62: clock cycles per duty step; a generator high time of UNIT*d+1 cycles decodes to d.
- MAX_DUTY, 100: saturation value of the duty result.
- TIMEOUT, 8191: cycles without any edge before a line is declared static.
- SYNC_STAGES, 2: input synchronizer depth, minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  CH  raw PWM lines, asynchronous to clk.
- duty  out  7*CH  recovered duty; channel i occupies bits [7i+6:7i].
- valid  out  CH  one-cycle strobe per channel when that channel's duty field updates.
- period_err  out  CH  sticky period error flags; see Optional Feature.

Behaviour:
- Reset: duty=0, valid=0, period_err=0, all synchronizer flops=0, all counters=0, every channel state=IDLE.
- Reset is asynchronous; asserting it mid-measurement discards the partial measurement.
- Synchronization and edges: each line passes through SYNC_STAGES flops. Rising and falling edges are detected on the synchronized signal against a one-cycle-delayed copy.
- Per-channel counters:
  - pre: 0..UNIT-1, counts clock cycles within one duty step.
  - units: 7 bits, saturates at MAX_DUTY.
  - idle: 13 bits, saturates at TIMEOUT, cleared on any edge.
- State IDLE (no valid period reference yet):
  - Rising edge: clear pre and units, go to HIGH. No publish.
  - Falling edge: go to LOW, units=0.
- State HIGH:
  - Each cycle pre increments; when pre wraps UNIT-1 to 0, units increments (saturating).
  - Falling edge: latch units into held, go to LOW.
- State LOW:
  - Rising edge: duty field <= min(held, MAX_DUTY); valid pulses for 1 cycle; clear pre, units, and the period counter; go to HIGH.
- Latency: duty and valid update on the cycle after the synchronized rising edge is detected. This is SYNC_STAGES+1 cycles after the pin edge.
- The reported duty always belongs to the previous full period, measured rising edge to rising edge.
- Rounding: duty = floor(high_cycles/UNIT). A 1-cycle high decodes to 0; UNIT*d+1 cycles decodes to d.
- Timeout: when idle reaches TIMEOUT, publish MAX_DUTY if the synchronized level is 1, otherwise 0. Pulse valid once, go to IDLE. idle then holds at TIMEOUT, so there are no further strobes until an edge occurs.
- Simultaneous edge and timeout on the same cycle: the edge wins and the timeout is not reported.
- Channels are fully independent; simultaneous strobes on several channels are legal.

Optional Feature:
- Macro PWM_PERIOD_CHECK_EN.
- With the macro defined:
  - A 14-bit per-channel period counter runs from rising edge to rising edge.
  - At each publish, if period < PERIOD_MIN (6000) or > PERIOD_MAX (6400), set period_err[i].
  - PERIOD_MIN and PERIOD_MAX are package constants.
  - period_err is cleared only by rst.
  - A timeout also sets period_err[i].
- Without the macro: period_err is tied to 0, and the period counter and its comparators are not built.

Decomposition:
- Package pwm_pkg holds:
  - DUTY_W=7, PWM_UNIT=62, PWM_MAX_DUTY=100, PWM_TIMEOUT=8191, PERIOD_MIN, PERIOD_MAX.
  - Channel state encoding IDLE/HIGH/LOW.
  - These constants are shared with the generator.
- One sub-module, pwm_capture_ch: a single channel containing synchronizer, edge detect, FSM, counters and optional period check.
- The top instantiates CH copies and packs the duty fields.

Test Plan:
- Duty 50, ch0: 3101 cycles high / 3100 low, repeated. The first rising edge publishes nothing; from the second rising edge on, duty[6:0]=50 with one valid[0] strobe per period; period_err[0]=0.
- Minimum and maximum pulses: ch1 with 1 cycle high per 6201-cycle period gives duty[13:7]=0. High for 6201 of 6202 cycles gives 100 (saturated, not 101+).
- Static lines: after reset, ch2 held low. At cycle TIMEOUT after the synchronized level settles, duty[20:14]=0 with exactly one valid[2]. ch3 held high gives duty[27:21]=100 with exactly one strobe.
- Reset mid-measurement: ch0 running duty 30, rst asserted asynchronously mid-high. All outputs are 0 immediately. After release, the first full period publishes 30, with no stale value.
- Boundary rounding: high lengths 61, 62, 63 and 124 cycles, period 6201, decode to 0, 1, 1 and 2.
- PWM_PERIOD_CHECK_EN defined: a period of 5000 cycles sets period_err and it stays set. Without the macro, the same stimulus leaves period_err=0 and duty is still correct.
